// File: rtl/branch_ctrl_pkg.sv
// Shared control-flow definitions for the branch/PC stage: opcode encodings
// and the flag-condition evaluator used when a conditional jump commits.
package branch_ctrl_pkg;

    localparam int unsigned BR_OP_W = 4;

    localparam logic [BR_OP_W-1:0] BR_NOP  = 4'd0;
    localparam logic [BR_OP_W-1:0] BR_JMP  = 4'd1;
    localparam logic [BR_OP_W-1:0] BR_JZ   = 4'd2;
    localparam logic [BR_OP_W-1:0] BR_JNZ  = 4'd3;
    localparam logic [BR_OP_W-1:0] BR_JC   = 4'd4;
    localparam logic [BR_OP_W-1:0] BR_JNC  = 4'd5;
    localparam logic [BR_OP_W-1:0] BR_JB   = 4'd6;
    localparam logic [BR_OP_W-1:0] BR_JNB  = 4'd7;
    localparam logic [BR_OP_W-1:0] BR_CALL = 4'd8;
    localparam logic [BR_OP_W-1:0] BR_RET  = 4'd9;
    localparam logic [BR_OP_W-1:0] BR_HALT = 4'd10;
    localparam logic [BR_OP_W-1:0] BR_RETI = 4'd11;

    // Returns 1 when a conditional jump opcode is satisfied by the flags;
    // every non-conditional opcode yields 0.
    function automatic logic br_cond_taken(
        input logic [BR_OP_W-1:0] op,
        input logic               c,
        input logic               z,
        input logic               b
    );
        logic t;
        t = 1'b0;
        case (op)
            BR_JZ:   t = z;
            BR_JNZ:  t = ~z;
            BR_JC:   t = c;
            BR_JNC:  t = ~c;
            BR_JB:   t = b;
            BR_JNB:  t = ~b;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage : branch_ctrl_pkg

// File: rtl/branch_ctrl_ret_stack.sv
// Return-address LIFO. A push while full or a pop while empty is refused,
// leaves the stored entries untouched and raises a sticky error flag.
module ret_stack #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [DATA_W-1:0]        push_data_i,
    output logic [DATA_W-1:0]        top_c,
    output logic                     full_c,
    output logic                     empty_c,
    output logic [$clog2(DEPTH):0]   depth_o,
    output logic                     ovf_o,
    output logic                     unf_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned DW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DW-1:0]     depth_q;
    logic              ovf_q;
    logic              unf_q;

    assign full_c  = (depth_q == DW'(DEPTH));
    assign empty_c = (depth_q == '0);
    assign top_c   = mem_q[AW'(depth_q - DW'(1))];
    assign depth_o = depth_q;
    assign ovf_o   = ovf_q;
    assign unf_o   = unf_q;

    // Occupancy counter and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (push_i) begin
            if (full_c) begin
                ovf_q <= 1'b1;
            end else begin
                depth_q <= depth_q + DW'(1);
            end
        end else if (pop_i) begin
            if (empty_c) begin
                unf_q <= 1'b1;
            end else begin
                depth_q <= depth_q - DW'(1);
            end
        end
    end

    // Entry storage; contents are meaningless after reset so it has none.
    always_ff @(posedge clk) begin
        if (push_i && !full_c) begin
            mem_q[AW'(depth_q)] <= push_data_i;
        end
    end

endmodule : ret_stack

// File: rtl/branch_ctrl.sv
// Program counter and branch resolution stage feeding the instruction ROM.
// Optional interrupt entry/return is enabled by defining BRANCH_CTRL_IRQ_EN.
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 8,
    parameter int unsigned       STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC   = '0
`ifdef BRANCH_CTRL_IRQ_EN
    ,
    parameter logic [ADDR_W-1:0] IRQ_VEC     = ADDR_W'(8'hF0)
`endif
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         pc_en,
    input  logic [BR_OP_W-1:0]           br_op,
    input  logic [ADDR_W-1:0]            br_target,
    input  logic                         flag_c,
    input  logic                         flag_z,
    input  logic                         flag_b,
    output logic [ADDR_W-1:0]            pc_addr,
    output logic                         pc_taken,
    output logic                         pc_halted,
    output logic [$clog2(STACK_DEPTH):0] sp_depth,
    output logic                         stack_ovf,
    output logic                         stack_unf
`ifdef BRANCH_CTRL_IRQ_EN
    ,
    input  logic                         irq_req,
    output logic                         irq_ack,
    output logic                         in_isr
`endif
);

    localparam int unsigned SP_W = $clog2(STACK_DEPTH) + 1;

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_seq_c;
    logic [ADDR_W-1:0] push_data_c;
    logic [ADDR_W-1:0] stk_top_c;
    logic              taken_q;
    logic              taken_d;
    logic              halted_q;
    logic              halted_d;
    logic              push_c;
    logic              pop_c;
    logic              stk_full_c;
    logic              stk_empty_c;
    logic [SP_W-1:0]   stk_depth;
    logic              stk_ovf;
    logic              stk_unf;
`ifdef BRANCH_CTRL_IRQ_EN
    logic              isr_q;
    logic              isr_d;
    logic              ack_q;
    logic              ack_d;
    logic              irq_take_c;
`endif

    ret_stack #(
        .DEPTH  (STACK_DEPTH),
        .DATA_W (ADDR_W)
    ) u_ret_stack (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push_c),
        .pop_i       (pop_c),
        .push_data_i (push_data_c),
        .top_c       (stk_top_c),
        .full_c      (stk_full_c),
        .empty_c     (stk_empty_c),
        .depth_o     (stk_depth),
        .ovf_o       (stk_ovf),
        .unf_o       (stk_unf)
    );

    assign pc_seq_c = pc_q + ADDR_W'(1);

    // Next-PC selection: interrupt entry first, then the committed opcode.
    always_comb begin
        pc_d        = pc_q;
        taken_d     = 1'b0;
        halted_d    = halted_q;
        push_c      = 1'b0;
        pop_c       = 1'b0;
        push_data_c = pc_seq_c;
`ifdef BRANCH_CTRL_IRQ_EN
        isr_d       = isr_q;
        ack_d       = 1'b0;
        irq_take_c  = pc_en & irq_req & ~isr_q & ~stk_full_c;
        if (irq_take_c) begin
            // A halted core resumes after its HALT instruction on return.
            push_c      = 1'b1;
            push_data_c = halted_q ? pc_seq_c : pc_q;
            pc_d        = IRQ_VEC;
            isr_d       = 1'b1;
            ack_d       = 1'b1;
            taken_d     = 1'b1;
            halted_d    = 1'b0;
        end else
`endif
        if (pc_en && !halted_q) begin
            case (br_op)
                BR_JMP: begin
                    pc_d    = br_target;
                    taken_d = 1'b1;
                end
                BR_JZ, BR_JNZ, BR_JC, BR_JNC, BR_JB, BR_JNB: begin
                    if (br_cond_taken(br_op, flag_c, flag_z, flag_b)) begin
                        pc_d    = br_target;
                        taken_d = 1'b1;
                    end else begin
                        pc_d = pc_seq_c;
                    end
                end
                BR_CALL: begin
                    // Stack refuses the push when full and flags overflow.
                    push_c = 1'b1;
                    if (!stk_full_c) begin
                        pc_d    = br_target;
                        taken_d = 1'b1;
                    end else begin
                        pc_d = pc_seq_c;
                    end
                end
                BR_RET: begin
                    pop_c = 1'b1;
                    if (!stk_empty_c) begin
                        pc_d    = stk_top_c;
                        taken_d = 1'b1;
                    end else begin
                        pc_d = pc_seq_c;
                    end
                end
                BR_HALT: begin
                    halted_d = 1'b1;
                end
`ifdef BRANCH_CTRL_IRQ_EN
                BR_RETI: begin
                    pop_c = 1'b1;
                    isr_d = 1'b0;
                    if (!stk_empty_c) begin
                        pc_d    = stk_top_c;
                        taken_d = 1'b1;
                    end else begin
                        pc_d = pc_seq_c;
                    end
                end
`endif
                default: begin
                    pc_d = pc_seq_c;
                end
            endcase
        end
    end

    // PC, transfer pulse and halt/ISR state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_VEC;
            taken_q  <= 1'b0;
            halted_q <= 1'b0;
`ifdef BRANCH_CTRL_IRQ_EN
            isr_q    <= 1'b0;
            ack_q    <= 1'b0;
`endif
        end else begin
            pc_q     <= pc_d;
            taken_q  <= taken_d;
            halted_q <= halted_d;
`ifdef BRANCH_CTRL_IRQ_EN
            isr_q    <= isr_d;
            ack_q    <= ack_d;
`endif
        end
    end

    assign pc_addr   = pc_q;
    assign pc_taken  = taken_q;
    assign pc_halted = halted_q;
    assign sp_depth  = stk_depth;
    assign stack_ovf = stk_ovf;
    assign stack_unf = stk_unf;
`ifdef BRANCH_CTRL_IRQ_EN
    assign irq_ack   = ack_q;
    assign in_isr    = isr_q;
`endif

endmodule : branch_ctrl

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Program-counter and branch-resolution stage directly downstream of the flag register.
- Consumes registered carry/zero/borrow flags and the decoded control-flow opcode, and produces the instruction-memory address for the next cycle.
- Holds a small return-address stack for CALL/RET and a sticky halt state.
- Sits between the decoder/flag register and the instruction ROM address input.

Parameters:
- ADDR_W, 8, program counter / target width in bits
- STACK_DEPTH, 4, number of return-address entries (power of two, min 2)
- RESET_VEC, 0, PC value after reset
- IRQ_VEC, 8'hF0, interrupt entry address (used only with the optional feature)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- pc_en  in  1  advance enable; 0 = stall, all state holds
- br_op  in  4  control-flow opcode from decoder
- br_target  in  ADDR_W  absolute jump/call target
- flag_c  in  1  carry flag
- flag_z  in  1  zero flag
- flag_b  in  1  borrow flag
- pc_addr  out  ADDR_W  current program counter (registered)
- pc_taken  out  1  one-cycle pulse: previous advance was a non-sequential transfer
- pc_halted  out  1  halt state
- sp_depth  out  $clog2(STACK_DEPTH)+1  occupied stack entries
- stack_ovf  out  1  sticky overflow error
- stack_unf  out  1  sticky underflow error

Behaviour:
- Reset (async, rst_n=0) values:
  - pc_addr=RESET_VEC; sp_depth=0; pc_taken=0; pc_halted=0; stack_ovf=0; stack_unf=0.
  - Stack contents are don't-care after reset.
- Flags are sampled at the same rising edge that commits br_op. Flags updated mid-cycle upstream must be settled before that edge.
- Opcodes:
  - 0 NOP/SEQ
  - 1 JMP
  - 2 JZ
  - 3 JNZ
  - 4 JC
  - 5 JNC
  - 6 JB
  - 7 JNB
  - 8 CALL
  - 9 RET
  - 10 HALT
  - 11 RETI
  - 12-15 reserved, behave as NOP.
- Advance happens on a rising edge when pc_en=1 and pc_halted=0. Otherwise every register holds and pc_taken=0.
- Sequential next PC is pc_addr+1 modulo 2^ADDR_W; the maximum address wraps to 0.
- Conditional jump taken -> pc_addr=br_target, pc_taken=1 next cycle. Not taken -> sequential, pc_taken=0.
- CALL:
  - sp_depth<STACK_DEPTH: push pc_addr+1, sp_depth+1, pc_addr=br_target, pc_taken=1.
  - Stack full: stack_ovf<=1, no push, sequential advance.
- RET:
  - sp_depth>0: pop into pc_addr, sp_depth-1, pc_taken=1.
  - Empty: stack_unf<=1, sequential advance.
- HALT: pc_addr holds at the HALT address; pc_halted<=1. It clears only on reset, or on interrupt entry when the optional feature is present.
- Error flags are sticky until reset. An error never corrupts existing stack entries.
- Reset asserted mid-operation overrides everything asynchronously. Stack state is discarded.
- Latency: a one-cycle, single-issue control-flow path. The new pc_addr is visible immediately after the committing edge.

Optional Feature:
- Macro: BRANCH_CTRL_IRQ_EN.
- With the macro defined, extra ports: irq_req in 1 (level), irq_ack out 1 (one-cycle pulse), in_isr out 1.
- Interrupt entry:
  - Conditions: on an edge with pc_en=1, irq_req=1, in_isr=0 and sp_depth<STACK_DEPTH.
  - The interrupt is taken instead of br_op, and the current op is not executed.
  - Push pc_addr, or pc_addr+1 if halted.
  - pc_addr=IRQ_VEC; in_isr=1; irq_ack=1; pc_taken=1; pc_halted<=0.
- The entry rule applies while halted as well; this is the wake-up path.
- A full stack or in_isr=1 leaves the request pending. There is no nesting.
- RETI: pops like RET and clears in_isr. Underflow is handled like RET.
- Without the macro: the irq ports do not exist and RETI behaves as NOP.

Decomposition:
- Shared package holds:
  - Opcode localparams: BR_NOP..BR_RETI.
  - Opcode width constant BR_OP_W=4.
  - Condition-evaluation function mapping (op, c, z, b) -> taken.
- One natural sub-module: ret_stack, a LIFO with push/pop/full/empty/depth and the overflow/underflow guard.
- branch_ctrl instantiates ret_stack and holds the PC register and halt/ISR state.

Test Plan:
- Reset then pc_en=1, br_op=NOP for 5 cycles -> pc_addr 0,1,2,3,4,5, pc_taken=0. Stall one cycle -> value holds.
- PC at 8'hFF with NOP -> pc_addr=8'h00, no error.
- flag_z=1: JZ target 8'h40 -> pc_addr=8'h40, pc_taken=1. flag_z=0: JZ -> sequential. Repeat for JC/JNC/JB/JNB with flag_c/flag_b.
- Four CALLs from PCs 1,0x11,0x21,0x31 to targets 0x10,0x20,0x30,0x40 -> sp_depth=4.
- Fifth CALL -> stack_ovf=1, sequential advance.
- Five RETs from the resulting state -> PC sequence 0x32,0x22,0x12,0x02, then stack_unf=1.
- HALT at 0x05 -> pc_addr stays 0x05, pc_halted=1 for 10 cycles.
- rst_n pulsed low mid-cycle -> immediate pc_addr=RESET_VEC and all flags 0.
- With BRANCH_CTRL_IRQ_EN: irq_req while halted at 0x05 -> pc_addr=0xF0, irq_ack pulse, in_isr=1.
- Same scenario continued: RETI -> pc_addr=0x06, in_isr=0. A second irq_req during the ISR is deferred until after RETI.
